// File: rtl/instruction_assembler_if.sv
// Interface bundling the field-set input handshake and the encoded-word
// output handshake of instruction_assembler.
// Optional macro INSTR_ASM_CHECK_EN adds the per-word err flag.
interface instruction_assembler_if #(
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         fmt;
  logic [6:0]         opcode;
  logic [4:0]         rd;
  logic [2:0]         funct3;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [6:0]         funct7;
  logic [31:0]        imm;
  logic [31:0]        Instruction;
  logic               out_valid;
  logic               out_ready;
  logic [COUNT_W-1:0] count;
`ifdef INSTR_ASM_CHECK_EN
  logic               err;

  modport master (
    output in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    input  in_ready, Instruction, out_valid, count, err
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    output in_ready, Instruction, out_valid, count, err
  );
`else
  modport master (
    output in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    input  in_ready, Instruction, out_valid, count
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    output in_ready, Instruction, out_valid, count
  );
`endif
endinterface

// File: rtl/instruction_assembler.sv
// instruction_assembler: packs RISC-V style instruction fields into a 32-bit
// word according to fmt and buffers the result in a small FIFO with
// valid/ready handshakes on both sides. Counts completed output handshakes.
// Optional macro INSTR_ASM_CHECK_EN: stores a legality flag per entry and
// presents it on err next to the head word.
module instruction_assembler #(
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 16
) (
  input logic clk,
  input logic reset,
  instruction_assembler_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic [COUNT_W-1:0] count_q;
  logic [31:0]        enc_word;
  logic               push;
  logic               pop;

  assign bus.in_ready  = (occ < OCC_W'(DEPTH));
  assign bus.out_valid = (occ != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  // The head word is gated so an empty FIFO never exposes stale storage.
  assign bus.Instruction = bus.out_valid ? mem[rd_ptr] : 32'h0;
  assign bus.count       = count_q;

  // Field packing per format; reserved formats collapse to a NOP so that no
  // input field can leak into the word.
  always_comb begin
    enc_word = NOP;
    case (bus.fmt)
      3'd0: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd1: enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd2: enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0],
                        bus.opcode};
      3'd3: enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                        bus.imm[4:1], bus.imm[11], bus.opcode};
      3'd4: enc_word = {bus.imm[31:12], bus.rd, bus.opcode};
      3'd5: enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                        bus.rd, bus.opcode};
      default: enc_word = NOP;
    endcase
  end

  // Storage write; entries need no reset because reads are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // Pointers, occupancy and handshake counter; reset drops all buffered words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        count_q <= count_q + COUNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

`ifdef INSTR_ASM_CHECK_EN
  logic err_mem [DEPTH];
  logic enc_err;

  // Legality flag: reserved format, non-32-bit opcode, or odd branch/jump offset.
  always_comb begin
    enc_err = 1'b0;
    if (bus.fmt[2:1] == 2'b11) begin
      enc_err = 1'b1;
    end
    if (bus.opcode[1:0] != 2'b11) begin
      enc_err = 1'b1;
    end
    if (((bus.fmt == 3'd3) || (bus.fmt == 3'd5)) && bus.imm[0]) begin
      enc_err = 1'b1;
    end
  end

  // Flag storage written alongside the encoded word.
  always_ff @(posedge clk) begin
    if (push) begin
      err_mem[wr_ptr] <= enc_err;
    end
  end

  assign bus.err = bus.out_valid && err_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_instruction_assembler.sv
// Randomized and directed bench for instruction_assembler with a queue-based
// reference model; encodings are built by shifting fields into position.
module tb_instruction_assembler;
  localparam int DEPTH   = 2;
  localparam int COUNT_W = 5;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cnt;
  logic [32:0] q[$];

  instruction_assembler_if #(.COUNT_W(COUNT_W)) bus ();

  instruction_assembler #(.DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_enc(input int f, input logic [31:0] op,
      input logic [31:0] rdv, input logic [31:0] f3, input logic [31:0] r1,
      input logic [31:0] r2, input logic [31:0] f7, input logic [31:0] im);
    logic [31:0] base;
    base = (f3 << 12) | op;
    case (f)
      0: return (f7 << 25) | (r2 << 20) | (r1 << 15) | base | (rdv << 7);
      1: return ((im & 32'hfff) << 20) | (r1 << 15) | base | (rdv << 7);
      2: return (((im >> 5) & 32'h7f) << 25) | (r2 << 20) | (r1 << 15) | base
                | ((im & 32'h1f) << 7);
      3: return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3f) << 25) | (r2 << 20)
                | (r1 << 15) | base | (((im >> 1) & 32'hf) << 8) | (((im >> 11) & 1) << 7);
      4: return (im & 32'hffff_f000) | (rdv << 7) | op;
      5: return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3ff) << 21)
                | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hff) << 12) | (rdv << 7) | op;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic model_err(input int f, input logic [31:0] op, input logic [31:0] im);
    return (f >= 6) || ((op % 4) != 3) || (((f == 3) || (f == 5)) && (im % 2 == 1));
  endfunction

  task automatic set_fields(input int f, input int op, input int rdv, input int f3,
      input int r1, input int r2, input int f7, input logic [31:0] im);
    bus.fmt    = 3'(f);
    bus.opcode = 7'(op);
    bus.rd     = 5'(rdv);
    bus.funct3 = 3'(f3);
    bus.rs1    = 5'(r1);
    bus.rs2    = 5'(r2);
    bus.funct7 = 7'(f7);
    bus.imm    = im;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_word;
    exp_word = (q.size() > 0) ? q[0][31:0] : 32'h0;
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(q.size() < DEPTH));
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() > 0));
    chk({tag, ".instr"}, 64'(bus.Instruction), 64'(exp_word));
    chk({tag, ".count"}, 64'(bus.count), 64'(cnt % (1 << COUNT_W)));
`ifdef INSTR_ASM_CHECK_EN
    chk({tag, ".err"}, 64'(bus.err), 64'((q.size() > 0) ? q[0][32] : 1'b0));
`endif
  endtask

  // One clock: predict handshakes from the current inputs, advance the model.
  task automatic step(input string tag);
    bit push;
    bit pop;
    logic [32:0] e;
    push = bus.in_valid && (q.size() < DEPTH);
    pop  = bus.out_ready && (q.size() > 0);
    e = {model_err(int'(bus.fmt), 32'(bus.opcode), bus.imm),
         model_enc(int'(bus.fmt), 32'(bus.opcode), 32'(bus.rd), 32'(bus.funct3),
                   32'(bus.rs1), 32'(bus.rs2), 32'(bus.funct7), bus.imm)};
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      cnt++;
    end
    if (push) q.push_back(e);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] wa;
    logic [31:0] wb;
    logic [31:0] wc;
    total = 0;
    bad   = 0;
    cnt   = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_outputs("post_reset");

    // Basic R-type with one-cycle latency, then pop.
    set_fields(0, 7'h33, 3, 0, 1, 2, 0, 32'h0);
    bus.in_valid = 1'b1;
    step("r_push");
    bus.in_valid = 1'b0;
    chk("r_word", 64'(bus.Instruction), 64'h002081B3);
    bus.out_ready = 1'b1;
    step("r_pop");
    chk("r_count", 64'(bus.count), 64'd1);

    // Known encodings for R, I, B, J round trips.
    set_fields(0, 7'h2E, 8, 4, 26, 2, 1, 32'h0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step("r2_push");
    chk("r2_word", 64'(bus.Instruction), 64'h022D442E);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step("r2_pop");
    set_fields(1, 7'h13, 1, 0, 0, 0, 0, 32'd5);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step("i_push");
    chk("i_word", 64'(bus.Instruction), 64'h00500093);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step("i_pop");
    set_fields(3, 7'h63, 0, 0, 1, 2, 0, 32'd8);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step("b_push");
    chk("b_word", 64'(bus.Instruction), 64'h00208463);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step("b_pop");
    set_fields(5, 7'h6F, 1, 0, 0, 0, 0, 32'd8);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step("j_push");
    chk("j_word", 64'(bus.Instruction), 64'h008000EF);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step("j_pop");

    // Reserved format gives a NOP regardless of the other fields.
    set_fields(7, 7'h30, 31, 7, 31, 31, 127, 32'hFFFF_FFFF);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step("nop_push");
    chk("nop_word", 64'(bus.Instruction), 64'h00000013);
`ifdef INSTR_ASM_CHECK_EN
    chk("nop_err", 64'(bus.err), 64'd1);
`endif
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step("nop_pop");
`ifdef INSTR_ASM_CHECK_EN
    set_fields(0, 7'h30, 1, 0, 1, 1, 0, 32'h0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step("badop_push");
    chk("badop_err", 64'(bus.err), 64'd1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step("badop_pop");
    chk("empty_err", 64'(bus.err), 64'd0);
    set_fields(0, 7'h33, 3, 0, 1, 2, 0, 32'h0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step("legal_push");
    chk("legal_err", 64'(bus.err), 64'd0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step("legal_pop");
`endif

    // Backpressure: three back-to-back pushes into a two-entry FIFO.
    wa = model_enc(4, 32'h37, 32'd5, 0, 0, 0, 0, 32'hABCDE000);
    wb = model_enc(1, 32'h13, 32'd6, 32'd1, 32'd2, 0, 0, 32'd77);
    wc = model_enc(2, 32'h23, 0, 32'd2, 32'd3, 32'd4, 0, 32'd100);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_fields(4, 7'h37, 5, 0, 0, 0, 0, 32'hABCDE000);
    step("bp_a");
    set_fields(1, 7'h13, 6, 1, 2, 0, 0, 32'd77);
    step("bp_b");
    chk("bp_full", 64'(bus.in_ready), 64'd0);
    set_fields(2, 7'h23, 0, 2, 3, 4, 0, 32'd100);
    step("bp_hold");
    chk("bp_head_a", 64'(bus.Instruction), 64'(wa));
    bus.out_ready = 1'b1;
    step("bp_pop_a");
    chk("bp_head_b", 64'(bus.Instruction), 64'(wb));
    step("bp_pop_b_push_c");
    bus.in_valid = 1'b0;
    chk("bp_head_c", 64'(bus.Instruction), 64'(wc));
    step("bp_pop_c");

    // Reset with two words buffered discards them immediately.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_fields(0, 7'h33, 9, 0, 9, 9, 0, 32'h0);
    step("rst_fill1");
    step("rst_fill2");
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    q.delete();
    cnt = 0;
    chk("rst_async_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_async_instr", 64'(bus.Instruction), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("rst_after");
    set_fields(1, 7'h13, 1, 0, 0, 0, 0, 32'd5);
    bus.in_valid = 1'b1;
    step("rst_new_push");
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("rst_new_word", 64'(bus.Instruction), 64'h00500093);
    step("rst_new_pop");
    step("rst_new_empty");

    // Randomized traffic; long enough for the narrow counter to wrap.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      set_fields(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 127)), $urandom());
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
